// File: rtl/classify_stage_if.sv
// rtl/classify_stage_if.sv - bundle handshake interface for classify_stage
interface classify_stage_if #(
  parameter int LANES = 2
);
  logic                in_valid;
  logic                in_ready;
  logic [32*LANES-1:0] in_instr;
  logic [LANES-1:0]    in_lane_valid;
  logic                out_valid;
  logic                out_ready;
  logic [32*LANES-1:0] out_instr;
  logic [LANES-1:0]    out_lane_valid;
  logic [LANES-1:0]    out_is_r;
  logic [LANES-1:0]    out_is_i;
  logic [LANES-1:0]    out_is_j;
  logic [LANES-1:0]    out_illegal;

  modport master (
    output in_valid, in_instr, in_lane_valid, out_ready,
    input  in_ready, out_valid, out_instr, out_lane_valid,
           out_is_r, out_is_i, out_is_j, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_lane_valid, out_ready,
    output in_ready, out_valid, out_instr, out_lane_valid,
           out_is_r, out_is_i, out_is_j, out_illegal
  );
endinterface

// File: rtl/classify_stage.sv
// rtl/classify_stage.sv - registered multi-lane opcode classifier with two-entry skid buffer
// Optional per-class saturating counters compiled in with CLASSIFY_PERF_EN.
module classify_stage #(
  parameter int LANES = 2
`ifdef CLASSIFY_PERF_EN
  , parameter int COUNT_W = 32
`endif
) (
  input logic             clock,
  input logic             reset_n,
  input logic             flush,
  classify_stage_if.slave bus
`ifdef CLASSIFY_PERF_EN
  ,
  input  logic               stat_clear,
  output logic [COUNT_W-1:0] stat_r,
  output logic [COUNT_W-1:0] stat_i,
  output logic [COUNT_W-1:0] stat_j,
  output logic [COUNT_W-1:0] stat_illegal
`endif
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam logic [1:0] CL_R   = 2'd0;
  localparam logic [1:0] CL_I   = 2'd1;
  localparam logic [1:0] CL_J   = 2'd2;
  localparam logic [1:0] CL_ILL = 2'd3;

  typedef struct packed {
    logic [32*LANES-1:0] instr;
    logic [LANES-1:0]    lane_valid;
    logic [LANES-1:0]    is_r;
    logic [LANES-1:0]    is_i;
    logic [LANES-1:0]    is_j;
    logic [LANES-1:0]    illegal;
  } entry_t;

  logic [1:0] state;
  logic       in_ready_q;
  logic       out_valid_q;
  entry_t     main_q;
  entry_t     skid_q;
  entry_t     in_entry;
  logic       in_fire;
  logic       out_fire;

  function automatic logic [1:0] op_class(input logic [5:0] op);
    case (op)
      6'h00: op_class = CL_R;
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h09, 6'h0A,
      6'h0B, 6'h0D, 6'h0F, 6'h20, 6'h23, 6'h28, 6'h2B: op_class = CL_I;
      6'h02, 6'h03: op_class = CL_J;
      default: op_class = CL_ILL;
    endcase
  endfunction

  // Classify before the register so flags travel with the stored bundle.
  always_comb begin
    in_entry            = '0;
    in_entry.instr      = bus.in_instr;
    in_entry.lane_valid = bus.in_lane_valid;
    for (int k = 0; k < LANES; k++) begin
      in_entry.is_r[k]    = bus.in_lane_valid[k] && (op_class(bus.in_instr[32*k+26 +: 6]) == CL_R);
      in_entry.is_i[k]    = bus.in_lane_valid[k] && (op_class(bus.in_instr[32*k+26 +: 6]) == CL_I);
      in_entry.is_j[k]    = bus.in_lane_valid[k] && (op_class(bus.in_instr[32*k+26 +: 6]) == CL_J);
      in_entry.illegal[k] = bus.in_lane_valid[k] && (op_class(bus.in_instr[32*k+26 +: 6]) == CL_ILL);
    end
  end

  assign in_fire  = bus.in_valid && in_ready_q;
  assign out_fire = out_valid_q && bus.out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
    end else if (flush) begin
      state       <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_q      <= in_entry;
            state       <= ST_ONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_entry;
          end else if (in_fire) begin
            skid_q     <= in_entry;
            state      <= ST_TWO;
            in_ready_q <= 1'b0;
          end else if (out_fire) begin
            state       <= ST_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        ST_TWO: begin
          // Skid entry is always the older of what remains, so it moves up.
          if (out_fire) begin
            main_q     <= skid_q;
            state      <= ST_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= ST_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_instr      = main_q.instr;
  assign bus.out_lane_valid = main_q.lane_valid;
  assign bus.out_is_r       = main_q.is_r;
  assign bus.out_is_i       = main_q.is_i;
  assign bus.out_is_j       = main_q.is_j;
  assign bus.out_illegal    = main_q.illegal;

`ifdef CLASSIFY_PERF_EN
  function automatic logic [COUNT_W:0] lane_pop(input logic [LANES-1:0] v);
    lane_pop = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_pop = lane_pop + (COUNT_W+1)'(v[k]);
    end
  endfunction

  // One guard bit catches overflow; the sum then pins at all-ones.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c,
                                                 input logic [LANES-1:0]   flags);
    logic [COUNT_W:0] s;
    s = {1'b0, c} + lane_pop(flags);
    sat_inc = s[COUNT_W] ? {COUNT_W{1'b1}} : s[COUNT_W-1:0];
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_r       <= '0;
      stat_i       <= '0;
      stat_j       <= '0;
      stat_illegal <= '0;
    end else if (stat_clear) begin
      stat_r       <= '0;
      stat_i       <= '0;
      stat_j       <= '0;
      stat_illegal <= '0;
    end else if (out_fire) begin
      stat_r       <= sat_inc(stat_r, main_q.is_r);
      stat_i       <= sat_inc(stat_i, main_q.is_i);
      stat_j       <= sat_inc(stat_j, main_q.is_j);
      stat_illegal <= sat_inc(stat_illegal, main_q.illegal);
    end
  end
`endif

endmodule

// File: tb/tb_classify_stage.sv
// tb/tb_classify_stage.sv - table-driven and randomized bench for classify_stage
module tb_classify_stage;
  localparam int LANES   = 2;
  localparam int COUNT_W = 4;
  localparam int I_OPS[14] = '{1, 4, 5, 6, 7, 9, 10, 11, 13, 15, 32, 35, 40, 43};

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic flush   = 1'b0;

  always #5 clock = ~clock;

  classify_stage_if #(.LANES(LANES)) bus ();

`ifdef CLASSIFY_PERF_EN
  logic               stat_clear = 1'b0;
  logic [COUNT_W-1:0] stat_r, stat_i, stat_j, stat_illegal;
  classify_stage #(.LANES(LANES), .COUNT_W(COUNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .bus(bus.slave),
    .stat_clear(stat_clear), .stat_r(stat_r), .stat_i(stat_i),
    .stat_j(stat_j), .stat_illegal(stat_illegal)
  );
`else
  classify_stage #(.LANES(LANES)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .bus(bus.slave)
  );
`endif

  typedef struct {
    logic [63:0] instr;
    logic [1:0]  lv;
  } bundle_t;

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    logic [1:0]  lv;
    logic [1:0]  r;
    logic [1:0]  i;
    logic [1:0]  j;
    logic [1:0]  ill;
  } vec_t;

  bundle_t q[$];
  int errors = 0;
  int checks = 0;
  int cnt[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // 0=R 1=I 2=J 3=illegal, from the opcode lists directly.
  function automatic int cls_of(input logic [31:0] w);
    int op;
    op = int'(w[31:26]);
    if (op == 0) return 0;
    foreach (I_OPS[n]) if (I_OPS[n] == op) return 1;
    if (op == 2 || op == 3) return 2;
    return 3;
  endfunction

  // Packed as {illegal, j, i, r}, two lanes each.
  function automatic logic [7:0] exp_flags(input bundle_t b);
    logic [7:0] f;
    logic [31:0] w;
    f = '0;
    for (int k = 0; k < 2; k++) begin
      w = b.instr[32*k +: 32];
      if (b.lv[k]) f[cls_of(w)*2 + k] = 1'b1;
    end
    return f;
  endfunction

  task automatic cyc(input logic iv, input logic [63:0] instr, input logic [1:0] lv,
                     input logic ordy, input logic fl, input logic sc);
    logic [7:0] f;
    logic out_fire, in_fire;
    bundle_t nb;
    bus.in_valid      = iv;
    bus.in_instr      = instr;
    bus.in_lane_valid = lv;
    bus.out_ready     = ordy;
    flush             = fl;
`ifdef CLASSIFY_PERF_EN
    stat_clear        = sc;
`endif
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
    f = '0;
    if (q.size() > 0) begin
      f = exp_flags(q[0]);
      if (bus.out_valid) begin
        chk("out_instr", bus.out_instr, q[0].instr);
        chk("out_lane_valid", 64'(bus.out_lane_valid), 64'(q[0].lv));
        chk("out_is_r", 64'(bus.out_is_r), 64'(f[1:0]));
        chk("out_is_i", 64'(bus.out_is_i), 64'(f[3:2]));
        chk("out_is_j", 64'(bus.out_is_j), 64'(f[5:4]));
        chk("out_illegal", 64'(bus.out_illegal), 64'(f[7:6]));
      end
    end
    out_fire = ordy && (q.size() > 0);
    in_fire  = iv && (q.size() < 2);
`ifdef CLASSIFY_PERF_EN
    chk("stat_r", 64'(stat_r), 64'(cnt[0]));
    chk("stat_i", 64'(stat_i), 64'(cnt[1]));
    chk("stat_j", 64'(stat_j), 64'(cnt[2]));
    chk("stat_illegal", 64'(stat_illegal), 64'(cnt[3]));
    for (int c = 0; c < 4; c++) begin
      if (sc) cnt[c] = 0;
      else if (out_fire) begin
        cnt[c] = cnt[c] + $countones(f[2*c +: 2]);
        if (cnt[c] > (1 << COUNT_W) - 1) cnt[c] = (1 << COUNT_W) - 1;
      end
    end
`else
    if (sc) f = '0;
`endif
    if (fl) q.delete();
    else begin
      if (out_fire) void'(q.pop_front());
      if (in_fire) begin
        nb.instr = instr;
        nb.lv    = lv;
        q.push_back(nb);
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    w[31:26] = 6'($urandom_range(0, 63));
    if ($urandom_range(0, 3) == 0) w[31:26] = 6'($urandom_range(0, 3));
    return w;
  endfunction

  localparam logic [63:0] A = 64'h3C01000A_0085100A;
  localparam logic [63:0] B = 64'h0C10000B_8C22000B;
  localparam logic [63:0] C = 64'hFC00000C_0000000C;
  localparam logic [63:0] D = 64'h0800000D_AC22000D;
  localparam logic [63:0] RR = 64'h00851021_00A63021;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{32'h00851021, 32'h3C010000, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00};
    tbl[1] = '{32'h0C100000, 32'hFC000000, 2'b11, 2'b00, 2'b00, 2'b01, 2'b10};
    tbl[2] = '{32'h0C100000, 32'hFC000000, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00};
    tbl[3] = '{32'h8C220004, 32'hAC220004, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00};
    tbl[4] = '{32'h08000000, 32'h20000000, 2'b11, 2'b00, 2'b00, 2'b01, 2'b10};
    tbl[5] = '{32'h00000000, 32'h00000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[6] = '{32'h3C000000, 32'h40000000, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10};
    for (int c = 0; c < 4; c++) cnt[c] = 0;

    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_lane_valid = '0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_instr", bus.out_instr, 64'd0);
    chk("rst_flags", 64'({bus.out_is_r, bus.out_is_i, bus.out_is_j, bus.out_illegal}), 64'd0);
`ifdef CLASSIFY_PERF_EN
    chk("rst_stats", 64'({stat_r, stat_i, stat_j, stat_illegal}), 64'd0);
`endif
    reset_n = 1'b1;

    // Classification table, one bundle per cycle with out_ready high.
    for (int n = 0; n < 7; n++) begin
      cyc(1'b1, {tbl[n].w1, tbl[n].w0}, tbl[n].lv, 1'b1, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_r", n), 64'(bus.out_is_r), 64'(tbl[n].r));
      chk($sformatf("tbl%0d_i", n), 64'(bus.out_is_i), 64'(tbl[n].i));
      chk($sformatf("tbl%0d_j", n), 64'(bus.out_is_j), 64'(tbl[n].j));
      chk($sformatf("tbl%0d_ill", n), 64'(bus.out_illegal), 64'(tbl[n].ill));
    end
    cyc(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b0);

    // Backpressure: A and B fill the buffer, C waits and follows without gaps.
    cyc(1'b1, A, 2'b11, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, B, 2'b11, 1'b0, 1'b0, 1'b0);
    chk("bp_in_ready_c", 64'(bus.in_ready), 64'd0);
    cyc(1'b1, C, 2'b11, 1'b0, 1'b0, 1'b0);
    chk("bp_hold_a", bus.out_instr, A);
    cyc(1'b1, C, 2'b11, 1'b1, 1'b0, 1'b0);
    chk("bp_out_b", bus.out_instr, B);
    cyc(1'b1, C, 2'b11, 1'b1, 1'b0, 1'b0);
    chk("bp_out_c", bus.out_instr, C);
    chk("bp_valid_c", 64'(bus.out_valid), 64'd1);
    cyc(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("bp_drained", 64'(bus.out_valid), 64'd0);

    // Flush from TWO while a new bundle is offered.
    cyc(1'b1, A, 2'b11, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, B, 2'b11, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, D, 2'b11, 1'b0, 1'b1, 1'b0);
    chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
    chk("fl_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (3) cyc(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b0);

`ifdef CLASSIFY_PERF_EN
    cyc(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b1);
    repeat (20) cyc(1'b1, RR, 2'b11, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("cnt_sat_r", 64'(stat_r), 64'd15);
    cyc(1'b1, RR, 2'b11, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b1);
    chk("cnt_clear_r", 64'(stat_r), 64'd0);
`endif

    for (int n = 0; n < 400; n++) begin
      cyc(1'($urandom_range(0, 1)), {rand_word(), rand_word()}, 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0),
          1'($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset between edges with the buffer full.
    cyc(1'b1, A, 2'b11, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, B, 2'b11, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, C, 2'b11, 1'b0, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_out_valid", 64'(bus.out_valid), 64'd0);
    chk("ar_in_ready", 64'(bus.in_ready), 64'd1);
    chk("ar_out_instr", bus.out_instr, 64'd0);
`ifdef CLASSIFY_PERF_EN
    chk("ar_stats", 64'({stat_r, stat_i, stat_j, stat_illegal}), 64'd0);
`endif
    q.delete();
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    @(negedge clock);
    reset_n = 1'b1;
    cyc(1'b1, D, 2'b01, 1'b1, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/classify_stage.md
# classify_stage

Registered, multi-lane successor to the decode-stage opcode classifier. It accepts a bundle of `LANES` instruction words per cycle over a valid/ready handshake. Each lane is classified as R-, I-, J-type or illegal, and the bundle is presented one cycle later through a two-entry skid buffer, so upstream fetch never sees a combinational ready path. Optional saturating per-class counters feed the performance/debug block.

## Interface
- `LANES`, 2, instruction lanes per bundle (1..4).
- `COUNT_W`, 32, width of each statistics counter.
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous; discards all buffered bundles.
- `in_valid`  in  1  upstream bundle valid.
- `in_ready`  out  1  block can accept a bundle; driven directly from a register.
- `in_instr`  in  32*LANES  lane k occupies bits [32k+31:32k].
- `in_lane_valid`  in  LANES  per-lane valid within bundle.
- `out_valid`  out  1  output bundle valid.
- `out_ready`  in  1  downstream accepts.
- `out_instr`  out  32*LANES  registered copy of the accepted instructions.
- `out_lane_valid`  out  LANES  registered lane valids.
- `out_is_r`, `out_is_i`, `out_is_j`, `out_illegal`  out  LANES each  per-lane class flags.
- `stat_clear`  in  1  synchronous counter clear (only present with PERF).
- `stat_r`, `stat_i`, `stat_j`, `stat_illegal`  out  COUNT_W each  counters (only present with PERF).

## Operation
- Opcode is bits [31:26] of each lane.
- **R-type:** opcode 0x00.
- **I-type:** opcodes 0x01, 0x04, 0x05, 0x06, 0x07, 0x09, 0x0A, 0x0B, 0x0D, 0x0F, 0x20, 0x23, 0x28, 0x2B.
- **J-type:** opcodes 0x02 and 0x03.
- **Illegal:** a valid lane matching none of the above.
- **Per-lane flags:** exactly one of is_r/is_i/is_j/illegal is high for a valid lane. All four are 0 for an invalid lane.
- **Classification point:** on the input side, before the register. Flags are stored alongside the instruction.
- **Buffer states:**
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: main register full; out_valid=1, in_ready=1.
  - TWO: main and skid full; out_valid=1, in_ready=0.
- **Transitions:**
  - Input transfer without output transfer: EMPTY→ONE or ONE→TWO.
  - Output transfer without input transfer: TWO→ONE (skid moves to main) or ONE→EMPTY.
  - Both transfers in ONE: stay in ONE, main reloaded with the new bundle.
  - TWO cannot accept input.
- **Ordering:** bundles leave in strict arrival order; no reordering and no duplication.
- **Flush:** next state is EMPTY regardless of in_valid/out_ready. A bundle offered in the flush cycle is dropped.
- **Counters** update on output transfer (out_valid & out_ready) only.
  - Each counter adds popcount of its class flags over valid lanes.
  - Counters saturate at 2^COUNT_W−1; no wrap.
  - stat_clear has priority over the same-cycle increment, which is discarded.
  - flush does not affect counters.

## Timing
- **Reset values:** state EMPTY, in_ready=1, out_valid=0, all out_* data and flags 0, all stat_* 0.
- **Latency:** 1 cycle. A bundle accepted at edge N appears with out_valid=1 after edge N when the buffer was EMPTY.
- **Throughput:** one bundle/cycle while out_ready=1.
- **in_ready:** depends only on registered state, never on out_ready in the same cycle.
- **Output hold:** out_* stay stable while out_valid=1 and out_ready=0.
- **Reset mid-operation:** asynchronous assertion clears state immediately. Buffered bundles are lost.
- **Counter visibility:** stat_* reflect a transfer on the following cycle.

## Configuration
- Macro `CLASSIFY_PERF_EN`.
- **Defined:** stat_clear input, the four stat_* outputs and their counters are compiled in.
- **Undefined:** those ports and all counter logic are absent. Handshake and classification are unchanged.

## Test plan
- **Single lane classes:** LANES=2, lane0=0x00851021 (addu), lane1=0x3C010000 (lui), both valid, out_ready=1 → next cycle is_r=2'b01, is_i=2'b10, illegal=0.
- **J-type and illegal:** lane0=0x0C100000 (jal), lane1=0xFC000000 → is_j=2'b01, illegal=2'b10. Lane1 invalid with the same data → illegal=2'b00.
- **Backpressure:**
  - out_ready=0, push 3 bundles A, B, C → A and B accepted, in_ready=0 on the cycle C is offered.
  - Release out_ready → A, B, then C (re-offered) emerge in order with no gaps.
- **Flush with TWO entries and in_valid=1:** next cycle out_valid=0, in_ready=1, and no dropped bundle ever appears.
- **Counters (CLASSIFY_PERF_EN):**
  - With COUNT_W=4, 20 transfers of two R lanes → stat_r=15 (saturated).
  - stat_clear concurrent with a transfer → stat_r=0 next cycle.
- **Async reset:** assert reset_n=0 mid-stream between edges → out_valid=0 and in_ready=1 immediately. Counters read 0.
